mem_arbiter: RTL and testbench

Arbitrates the single AXI4 master bridge of the rv32i core between the instruction-fetch port (IF) and the data load/store port (MEM). It accepts one outstanding request at a time, sequences the command and response handshakes with the bridge, and returns read data and completion to the owning requester. It drives the IF and MEM stall signals that freeze the pipeline while an access is pending. A bounded-priority rule prevents either port from starving.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the IF/MEM bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
  typedef enum logic {OWN_IM, OWN_DM} arb_owner_e;

  localparam int unsigned DM_MAX_RUN_DEFAULT  = 4;
  localparam int unsigned WDOG_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the core's single bus bridge between instruction fetch and data access,
// one outstanding command at a time, with bounded data priority and a WAIT watchdog.
//
// state | meaning
// IDLE  | no access owned; grant the next pending requester
// ISSUE | command valid to the bridge, waiting for ack
// WAIT  | command accepted, waiting for response or watchdog expiry
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DM_MAX_RUN  = DM_MAX_RUN_DEFAULT,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_im_req,
  input  logic [31:0] i_im_addr,
  input  logic        i_im_flush,
  output logic        o_im_done,
  output logic [31:0] o_im_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_wstrb,
  output logic        o_dm_done,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_err,
  output logic        o_bus_req,
  input  logic        i_bus_ack,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_done,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err,
  output logic        o_if_stall,
  output logic        o_mem_stall
);

  localparam int unsigned RUN_W  = (DM_MAX_RUN > 0) ? $clog2(DM_MAX_RUN + 1) : 1;
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(DM_MAX_RUN);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic              drop_q;
  logic [RUN_W-1:0]  run_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              im_done_q, dm_done_q, dm_err_q;
  logic [31:0]       rdata_q;
  logic              im_pend, dm_pend;
  logic              grant, grant_im, finish, timeout;

  // A requester whose done is pulsing this cycle is not re-granted.
  assign im_pend = i_im_req & ~im_done_q;
  assign dm_pend = i_dm_req & ~dm_done_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_im = 1'b0;
    finish   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (im_pend || dm_pend) begin
          grant    = 1'b1;
          grant_im = im_pend && (!dm_pend || run_q == RUN_MAX);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (i_bus_ack) state_d = WAIT;
      end
      WAIT: begin
        if (i_bus_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_IM;
      drop_q      <= 1'b0;
      run_q       <= '0;
      wdog_q      <= '0;
      im_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      rdata_q     <= '0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_wstrb <= '0;
    end else begin
      im_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      dm_err_q  <= 1'b0;
      if (grant) begin
        owner_q     <= grant_im ? OWN_IM : OWN_DM;
        o_bus_we    <= grant_im ? 1'b0 : i_dm_we;
        o_bus_addr  <= grant_im ? i_im_addr : i_dm_addr;
        o_bus_wdata <= grant_im ? 32'h0 : i_dm_wdata;
        o_bus_wstrb <= (grant_im || !i_dm_we) ? 4'h0 : i_dm_wstrb;
        wdog_q      <= '0;
        drop_q      <= 1'b0;
        if (grant_im)                      run_q <= '0;
        else if (im_pend && run_q != RUN_MAX) run_q <= run_q + 1'b1;
      end
      if (state_q != IDLE && owner_q == OWN_IM && i_im_flush) drop_q <= 1'b1;
      if (state_q == WAIT) wdog_q <= wdog_q + 1'b1;
      if (finish) begin
        rdata_q   <= i_bus_rdata;
        im_done_q <= (owner_q == OWN_IM) && !drop_q && !i_im_flush;
        dm_done_q <= (owner_q == OWN_DM);
        dm_err_q  <= (owner_q == OWN_DM) && i_bus_err;
      end
      // An abandoned fetch is silently dropped; a data access reports an error.
      if (timeout) begin
        dm_done_q <= (owner_q == OWN_DM);
        dm_err_q  <= (owner_q == OWN_DM);
      end
    end
  end

  assign o_bus_req   = (state_q == ISSUE);
  assign o_im_done   = im_done_q;
  assign o_im_rdata  = rdata_q;
  assign o_dm_done   = dm_done_q;
  assign o_dm_rdata  = rdata_q;
  assign o_dm_err    = dm_err_q;
  assign o_if_stall  = i_im_req & ~im_done_q;
  assign o_mem_stall = i_dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int DM_MAX_RUN  = 4;
  localparam int WDOG_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req, im_flush, dm_req, dm_we;
  logic [31:0] im_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        bus_ack, bus_done, bus_err;
  logic [31:0] bus_rdata;
  logic        o_im_done, o_dm_done, o_dm_err, o_bus_req, o_bus_we;
  logic [31:0] o_im_rdata, o_dm_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_wstrb;
  logic        o_if_stall, o_mem_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DM_MAX_RUN(DM_MAX_RUN), .WDOG_CYCLES(WDOG_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .i_im_req(im_req), .i_im_addr(im_addr), .i_im_flush(im_flush),
    .o_im_done(o_im_done), .o_im_rdata(o_im_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_wstrb(dm_wstrb),
    .o_dm_done(o_dm_done), .o_dm_rdata(o_dm_rdata), .o_dm_err(o_dm_err),
    .o_bus_req(o_bus_req), .i_bus_ack(bus_ack), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
    .i_bus_done(bus_done), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err),
    .o_if_stall(o_if_stall), .o_mem_stall(o_mem_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Randomized traffic; the last sat_cycles keep both requesters asserted.
  task automatic run_random(input int cycles, input int sat_cycles);
    int          lat = 0;
    int          m_run = 0;
    int          dm_streak = 0;
    bit          sat;
    bit          prev_im_done = 0, prev_dm_done = 0, prev_req = 0;
    bit          m_busy = 0, m_issue = 0, m_own_dm = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, e_rdata = 0;
    logic [3:0]  m_wstrb = 0;
    bit          e_im = 0, e_dm = 0, e_err = 0;
    bit          im_pend, dm_pend;
    for (int c = 0; c < cycles; c++) begin
      tick;
      sat = (c >= cycles - sat_cycles);
      chk("bus_req", o_bus_req, m_issue);
      if (m_busy) begin
        chk("bus_addr", o_bus_addr, m_addr);
        chk("bus_we", o_bus_we, m_we);
        if (m_we) begin
          chk("bus_wdata", o_bus_wdata, m_wdata);
          chk("bus_wstrb", o_bus_wstrb, m_wstrb);
        end
      end
      chk("im_done", o_im_done, e_im);
      chk("dm_done", o_dm_done, e_dm);
      if (e_im) chk("im_rdata", o_im_rdata, e_rdata);
      if (e_dm) begin
        chk("dm_err", o_dm_err, e_err);
        if (!m_we) chk("dm_rdata", o_dm_rdata, e_rdata);
      end
      if (sat && o_bus_req && !prev_req) begin
        if (o_bus_addr[31]) dm_streak++;
        else begin
          chk("starve", dm_streak <= DM_MAX_RUN, 1);
          dm_streak = 0;
        end
      end
      prev_req = o_bus_req;

      if (prev_im_done || !im_req) begin
        im_req  = sat ? 1'b1 : ($urandom_range(0, 2) == 0);
        im_addr = $urandom & 32'h0003_FFFC;
      end
      if (prev_dm_done || !dm_req) begin
        dm_req   = sat ? 1'b1 : ($urandom_range(0, 2) == 0);
        dm_we    = $urandom_range(0, 1);
        dm_addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom);
      end
      bus_ack   = 1'b0;
      bus_done  = 1'b0;
      bus_rdata = $urandom;
      bus_err   = $urandom_range(0, 1);
      if (m_busy && m_issue) begin
        if ($urandom_range(0, 1) == 1) begin
          bus_ack = 1'b1;
          lat = $urandom_range(1, 5);
        end
      end else if (m_busy) begin
        lat--;
        if (lat == 0) bus_done = 1'b1;
      end
      settle;
      chk("if_stall", o_if_stall, im_req & ~e_im);
      chk("mem_stall", o_mem_stall, dm_req & ~e_dm);

      prev_im_done = e_im;
      prev_dm_done = e_dm;
      im_pend = im_req && !e_im;
      dm_pend = dm_req && !e_dm;
      e_im = 0;
      e_dm = 0;
      if (!m_busy) begin
        if (im_pend || dm_pend) begin
          m_own_dm = dm_pend && !(im_pend && m_run == DM_MAX_RUN);
          if (m_own_dm) begin
            if (im_pend && m_run < DM_MAX_RUN) m_run++;
            m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
          end else begin
            m_run = 0;
            m_addr = im_addr; m_we = 0;
          end
          m_busy = 1;
          m_issue = 1;
        end
      end else if (m_issue) begin
        if (bus_ack) m_issue = 0;
      end else if (bus_done) begin
        m_busy  = 0;
        e_im    = !m_own_dm;
        e_dm    = m_own_dm;
        e_rdata = bus_rdata;
        e_err   = bus_err;
      end
    end
  endtask

  initial begin
    int seen;
    rst = 1; im_req = 0; im_addr = 0; im_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    bus_ack = 0; bus_done = 0; bus_rdata = 0; bus_err = 0;

    tick; tick;
    chk("rst_bus_req", o_bus_req, 0);
    chk("rst_im_done", o_im_done, 0);
    chk("rst_dm_done", o_dm_done, 0);
    chk("rst_dm_err", o_dm_err, 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_stalls", {o_if_stall, o_mem_stall}, 0);
    rst = 0;
    tick;

    // single load: ack in cycle 1, done in cycle 3, completion in cycle 4
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; settle;
    chk("ld_stall0", o_mem_stall, 1);
    chk("ld_req0", o_bus_req, 0);
    tick; bus_ack = 1; settle;
    chk("ld_req1", o_bus_req, 1);
    chk("ld_addr1", o_bus_addr, 32'h100);
    chk("ld_stall1", o_mem_stall, 1);
    tick; bus_ack = 0; settle;
    chk("ld_req2", o_bus_req, 0);
    chk("ld_stall2", o_mem_stall, 1);
    tick; bus_done = 1; bus_rdata = 32'hDEAD_BEEF; settle;
    chk("ld_stall3", o_mem_stall, 1);
    chk("ld_done3", o_dm_done, 0);
    tick; bus_done = 0; bus_rdata = 0; settle;
    chk("ld_done4", o_dm_done, 1);
    chk("ld_rdata4", o_dm_rdata, 32'hDEAD_BEEF);
    chk("ld_err4", o_dm_err, 0);
    chk("ld_stall4", o_mem_stall, 0);
    chk("ld_req4", o_bus_req, 0);
    tick; dm_req = 0; settle;
    chk("ld_done5", o_dm_done, 0);
    chk("ld_req5", o_bus_req, 0);

    // store: fields held through ISSUE and WAIT
    tick; dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'h1234; dm_wstrb = 4'b0011; settle;
    for (int c = 1; c <= 3; c++) begin
      tick; bus_ack = (c == 1); bus_done = (c == 3); bus_rdata = $urandom; settle;
      chk("st_we", o_bus_we, 1);
      chk("st_addr", o_bus_addr, 32'h400);
      chk("st_wdata", o_bus_wdata, 32'h1234);
      chk("st_wstrb", o_bus_wstrb, 4'b0011);
    end
    tick; bus_done = 0; settle;
    chk("st_done", o_dm_done, 1);
    chk("st_err", o_dm_err, 0);
    tick; dm_req = 0; dm_we = 0; settle;

    // flush during WAIT: response swallowed, new fetch granted right after
    tick; im_req = 1; im_addr = 32'h40; settle;
    chk("fl_stall0", o_if_stall, 1);
    tick; bus_ack = 1; settle;
    chk("fl_addr1", o_bus_addr, 32'h40);
    chk("fl_we1", o_bus_we, 0);
    tick; bus_ack = 0; im_flush = 1; im_addr = 32'h80; settle;
    tick; im_flush = 0; bus_done = 1; bus_rdata = 32'h5555_AAAA; settle;
    tick; bus_done = 0; settle;
    chk("fl_no_done", o_im_done, 0);
    chk("fl_idle", o_bus_req, 0);
    tick; bus_ack = 1; settle;
    chk("fl_regrant", o_bus_req, 1);
    chk("fl_new_addr", o_bus_addr, 32'h80);
    tick; bus_ack = 0; settle;
    tick; bus_done = 1; bus_rdata = 32'h1111_2222; settle;
    tick; bus_done = 0; settle;
    chk("fl_done", o_im_done, 1);
    chk("fl_rdata", o_im_rdata, 32'h1111_2222);
    chk("fl_stall", o_if_stall, 0);
    tick; im_req = 0; settle;

    // watchdog: no response, 16 WAIT cycles, then error completion
    tick; dm_req = 1; dm_we = 0; dm_addr = 32'h200; settle;
    tick; bus_ack = 1; settle;
    seen = 0;
    for (int c = 2; c <= 17; c++) begin
      tick; bus_ack = 0; settle;
      if (o_dm_done) seen++;
    end
    chk("wdog_early", seen, 0);
    tick; settle;
    chk("wdog_done", o_dm_done, 1);
    chk("wdog_err", o_dm_err, 1);
    tick; dm_req = 0; settle;
    chk("wdog_pulse", o_dm_done, 0);

    // reset while in WAIT
    tick; dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'hCAFE; dm_wstrb = 4'hF; settle;
    tick; bus_ack = 1; settle;
    tick; bus_ack = 0; rst = 1; dm_req = 0; settle;
    tick; rst = 0; settle;
    chk("rw_bus_req", o_bus_req, 0);
    chk("rw_bus_addr", o_bus_addr, 0);
    chk("rw_bus_we", o_bus_we, 0);
    chk("rw_bus_wdata", o_bus_wdata, 0);
    chk("rw_bus_wstrb", o_bus_wstrb, 0);
    chk("rw_dones", {o_im_done, o_dm_done, o_dm_err}, 0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick; settle;
      if (o_im_done || o_dm_done || o_bus_req) seen++;
    end
    chk("rw_quiet", seen, 0);
    dm_we = 0;

    run_random(2100, 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
